sm_prefetch: RTL and testbench
==============================

# sm_prefetch

Instruction prefetch stage sitting between a multi-cycle instruction memory and the CPU core's fetch port. It generates sequential word addresses, issues one memory request at a time with a req/ack handshake, and buffers returned words in a small FIFO with their addresses. The core consumes them through a valid/ready interface. A taken branch in the core redirects fetch, flushes the buffer and discards any in-flight response.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RESET_PC`, 32'h0: word address fetched first after reset.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `redirect` in 1: core requests fetch restart (taken branch/jump).
- `redirectAddr` in 32: new word address, valid with `redirect`.
- `memReq` out 1: request to instruction memory.
- `memAddr` out 32: word address of the current request.
- `memAck` in 1: memory response strobe; `memData` is valid in the same cycle.
- `memData` in 32: returned instruction word.
- `instrValid` out 1: head of FIFO valid.
- `instrData` out 32: head instruction.
- `instrAddr` out 32: word address of the head instruction.
- `instrReady` in 1: core accepts the head this cycle.

## Operation
- Registers:
  - `fetchPc`: next address to request.
  - `reqAddr`: address latched at request issue; drives `memAddr`.
  - `state`.
  - FIFO of {addr, data}.
- Addresses are word addresses; increment is +1, modulo 2^32 (wrap from 32'hFFFFFFFF to 0 is legal).
- States:
  - **IDLE**: `memReq`=0.
    - If `redirect`: `fetchPc`←`redirectAddr`, flush; stay IDLE.
    - Else if FIFO count < DEPTH: `reqAddr`←`fetchPc`; → WAIT.
  - **WAIT**: `memReq`=1; `memAddr` held stable until ack.
    - `redirect` & `memAck`: data dropped, flush, `fetchPc`←`redirectAddr`; → IDLE.
    - `redirect` & !`memAck`: flush, `fetchPc`←`redirectAddr`; → DISCARD.
    - `memAck` (no redirect): push {`reqAddr`, `memData`}, `fetchPc`←`fetchPc`+1. If count_after < DEPTH (count_after = count + 1 − pop), then `reqAddr`←`fetchPc`+1 and stay WAIT (back-to-back). Else → IDLE.
  - **DISCARD**: `memReq`=1 with the old `reqAddr`.
    - On `memAck`: data dropped; → IDLE.
    - A further `redirect` in DISCARD only updates `fetchPc` and flushes again.
- Pop occurs when `instrValid` & `instrReady`. Push and pop in the same cycle are both performed.
- A flush clears the FIFO in the cycle after `redirect` and overrides any same-cycle pop or push.
- `memReq` is never deasserted before `memAck`. At most one request is outstanding.

## Timing
- Reset values:
  - `state`=IDLE, `fetchPc`=`reqAddr`=RESET_PC.
  - `memReq`=0, `memAddr`=RESET_PC.
  - `instrValid`=0; `instrData` and `instrAddr` are 0 when the FIFO is empty.
- Reset is asynchronous. Asserting it mid-request drops the request. The memory must tolerate `memReq` falling without ack.
- `memReq` is registered: first request one cycle after reset release or after leaving IDLE.
- Ack at cycle N → `instrValid`=1 at N+1 (registered FIFO, show-ahead head).
- `redirect` at cycle N:
  - `instrValid`=0 at N+1.
  - From IDLE or WAIT+ack: request for `redirectAddr` at N+2.
- Steady state with 1-cycle memory ack and a consuming core: one instruction per cycle.
- FIFO full: no new request. A request already in flight never overflows the FIFO, because requests are issued only when count < DEPTH.

## Structure
- Add to `sm_cpu.vh`: state encodings `PF_IDLE`, `PF_WAIT`, `PF_DISCARD` (2 bits).
- Sub-module `sm_fifo`:
  - Parameters `WIDTH` (64 here) and `DEPTH`.
  - Show-ahead output, synchronous `flush`.
  - Outputs `count`, `empty`, `full`.
  - Wrap-around pointers of log2(DEPTH)+1 bits.
- `sm_prefetch` holds the FSM, `fetchPc`, `reqAddr` and the space check.

## Test plan
- **Reset/stream:** memory acks 1 cycle after req with `memData`=addr+32'h100, `instrReady`=1. Required: `instrAddr`=0,1,2,3… with data 32'h100,32'h101…, one per cycle after the first ack.
- **Backpressure:** `instrReady`=0, DEPTH=4. Required: exactly 4 acks accepted, then `memReq`=0. When ready rises, entries pop in order 0..3 and fetch resumes at 4.
- **Redirect in WAIT without ack:** 3-cycle memory latency; `redirect` to 32'h40 mid-request. Required: `memReq` stays high with the old address until ack, that data never appears, and the next request is 32'h40.
- **Redirect with ack same cycle:** the acked word is dropped, `instrValid`=0 next cycle, and the first delivered `instrAddr` is `redirectAddr`.
- **Wrap:** redirect to 32'hFFFFFFFF. Required: delivered addresses are FFFFFFFF then 00000000.
- **Async reset mid-request:** `rst` pulsed while in WAIT. Required: `memReq`=0 and `instrValid`=0 immediately, and the first post-reset request is to RESET_PC.

Source files
------------

// File: rtl/sm_prefetch_pkg.sv
// Shared state encodings, FIFO entry layout and address helper for the
// instruction prefetch stage.
package sm_prefetch_pkg;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_WAIT    = 2'd1,
    PF_DISCARD = 2'd2
  } pfState_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } pfEntry_t;

  localparam int PF_ENTRY_W = $bits(pfEntry_t);

  // Word addresses wrap modulo 2^32.
  function automatic logic [31:0] nextPc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/sm_fifo.sv
// Show-ahead FIFO with synchronous flush; head is visible the cycle after push.
// Pushes while full and pops while empty are ignored; flush wins over both.
module sm_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic             doPush;
  logic             doPop;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign count  = wrPtr - rdPtr;
  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign dout   = empty ? '0 : mem[rdPtr[AW-1:0]];
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sm_prefetch.sv
// Sequential instruction prefetch: one outstanding memory request, words buffered
// with their addresses; ack-to-valid is one cycle, requests stop while the FIFO is full.
import sm_prefetch_pkg::*;

module sm_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirectAddr,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  output logic        instrValid,
  output logic [31:0] instrData,
  output logic [31:0] instrAddr,
  input  logic        instrReady
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 2;

  pfState_t    state, stateNext;
  logic [31:0] fetchPc, fetchPcNext;
  logic [31:0] reqAddr, reqAddrNext;
  logic        push, pop, flush;
  logic [AW:0] count;
  logic        fifoEmpty, fifoFull;
  logic [CW-1:0] countAfter;
  pfEntry_t    pushEntry, headEntry;

  assign memReq     = (state != PF_IDLE);
  assign memAddr    = reqAddr;
  assign instrValid = !fifoEmpty;
  assign instrData  = headEntry.data;
  assign instrAddr  = headEntry.addr;
  assign pop        = instrValid && instrReady;
  assign pushEntry  = '{addr: reqAddr, data: memData};
  assign countAfter = CW'(count) + CW'(1) - CW'(pop);

  always_comb begin
    stateNext   = state;
    fetchPcNext = fetchPc;
    reqAddrNext = reqAddr;
    push        = 1'b0;
    flush       = 1'b0;
    case (state)
      PF_IDLE: begin
        if (redirect) begin
          fetchPcNext = redirectAddr;
          flush       = 1'b1;
        end else if (!fifoFull) begin
          reqAddrNext = fetchPc;
          stateNext   = PF_WAIT;
        end
      end
      PF_WAIT: begin
        if (redirect) begin
          // The word in flight belongs to the old stream; drop it now or when it lands.
          fetchPcNext = redirectAddr;
          flush       = 1'b1;
          stateNext   = memAck ? PF_IDLE : PF_DISCARD;
        end else if (memAck) begin
          push        = 1'b1;
          fetchPcNext = nextPc(fetchPc);
          if (countAfter < CW'(DEPTH)) reqAddrNext = nextPc(fetchPc);
          else                         stateNext   = PF_IDLE;
        end
      end
      PF_DISCARD: begin
        if (redirect) begin
          fetchPcNext = redirectAddr;
          flush       = 1'b1;
        end
        if (memAck) stateNext = PF_IDLE;
      end
      default: stateNext = PF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= PF_IDLE;
      fetchPc <= RESET_PC;
      reqAddr <= RESET_PC;
    end else begin
      state   <= stateNext;
      fetchPc <= fetchPcNext;
      reqAddr <= reqAddrNext;
    end
  end

  sm_fifo #(
    .WIDTH (PF_ENTRY_W),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .din   (pushEntry),
    .pop   (pop),
    .dout  (headEntry),
    .count (count),
    .empty (fifoEmpty),
    .full  (fifoFull)
  );

endmodule

// File: tb/tb_sm_prefetch.sv
// Directed bench for sm_prefetch: a latency-programmable memory model returns
// addr+0x100, a monitor records every accepted {addr,data} head.
module tb_sm_prefetch;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirectAddr;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memAck;
  logic [31:0] memData;
  logic        instrValid;
  logic [31:0] instrData;
  logic [31:0] instrAddr;
  logic        instrReady;

  int          nChecks = 0;
  int          nErrors = 0;
  int          memLat  = 1;
  int          waitCnt = 0;
  int          ackCount = 0;
  logic [63:0] rxQ [$];

  sm_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect     (redirect),
    .redirectAddr (redirectAddr),
    .memReq       (memReq),
    .memAddr      (memAddr),
    .memAck       (memAck),
    .memData      (memData),
    .instrValid   (instrValid),
    .instrData    (instrData),
    .instrAddr    (instrAddr),
    .instrReady   (instrReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkRx(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] got;
    got = (idx < rxQ.size()) ? rxQ[idx] : 64'hFFFF_FFFF_FFFF_FFFF;
    checkVal(tag, got, {a, d});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst      = 1'b1;
    redirect = 1'b0;
    repeat (2) tick();
    rxQ.delete();
    ackCount = 0;
    rst      = 1'b0;
  endtask

  // Memory model: acks the memLat-th cycle of each request with addr+0x100.
  initial begin
    memAck  = 1'b0;
    memData = '0;
    forever begin
      @(negedge clk);
      memAck = 1'b0;
      if (rst || !memReq) begin
        waitCnt = 0;
      end else begin
        waitCnt++;
        if (waitCnt >= memLat) begin
          memAck  = 1'b1;
          memData = memAddr + 32'h100;
          waitCnt = 0;
          ackCount++;
        end
      end
    end
  end

  // A pop coinciding with a redirect is overridden by the flush, so it is not a delivery.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && instrValid && instrReady && !redirect)
        rxQ.push_back({instrAddr, instrData});
    end
  end

  initial begin
    rst          = 1'b1;
    redirect     = 1'b0;
    redirectAddr = '0;
    instrReady   = 1'b1;
    tick();
    checkVal("rst_memReq",  64'(memReq),     64'd0);
    checkVal("rst_memAddr", 64'(memAddr),    64'd0);
    checkVal("rst_valid",   64'(instrValid), 64'd0);
    checkVal("rst_data",    64'(instrData),  64'd0);
    checkVal("rst_addr",    64'(instrAddr),  64'd0);

    // Stream: one instruction per cycle after the first ack.
    memLat = 1;
    instrReady = 1'b1;
    doReset();
    tick();
    checkVal("st_req",   64'(memReq),     64'd1);
    checkVal("st_addr0", 64'(memAddr),    64'd0);
    checkVal("st_nval",  64'(instrValid), 64'd0);
    tick();
    checkVal("st_val",   64'(instrValid), 64'd1);
    checkVal("st_head",  {instrAddr, instrData}, {32'h0, 32'h100});
    repeat (8) tick();
    checkVal("st_count", 64'(rxQ.size()), 64'd8);
    for (int i = 0; i < 8; i++) checkRx("st_word", i, 32'(i), 32'(i) + 32'h100);

    // Backpressure: four acks fill the FIFO, then requests stop.
    instrReady = 1'b0;
    doReset();
    repeat (12) tick();
    checkVal("bp_acks",  64'(ackCount),   64'd4);
    checkVal("bp_req",   64'(memReq),     64'd0);
    checkVal("bp_val",   64'(instrValid), 64'd1);
    checkVal("bp_head",  64'(instrAddr),  64'd0);
    instrReady = 1'b1;
    repeat (10) tick();
    for (int i = 0; i < 5; i++) checkRx("bp_order", i, 32'(i), 32'(i) + 32'h100);

    // Redirect in WAIT without ack: old request completes and is discarded.
    memLat = 3;
    doReset();
    repeat (2) tick();
    redirectAddr = 32'h40;
    redirect     = 1'b1;
    tick();
    redirect = 1'b0;
    checkVal("rw_holdReq",  64'(memReq),  64'd1);
    checkVal("rw_holdAddr", 64'(memAddr), 64'd0);
    tick();
    checkVal("rw_idle",     64'(memReq),  64'd0);
    tick();
    checkVal("rw_newReq",   64'(memReq),  64'd1);
    checkVal("rw_newAddr",  64'(memAddr), 64'h40);
    repeat (7) tick();
    checkRx("rw_first", 0, 32'h40, 32'h140);

    // Redirect coinciding with ack: acked word dropped.
    memLat = 1;
    doReset();
    repeat (3) tick();
    checkVal("ra_preVal", 64'(instrValid), 64'd1);
    redirectAddr = 32'h80;
    redirect     = 1'b1;
    tick();
    redirect = 1'b0;
    checkVal("ra_nval", 64'(instrValid), 64'd0);
    checkVal("ra_idle", 64'(memReq),     64'd0);
    rxQ.delete();
    tick();
    checkVal("ra_req",  64'(memReq),  64'd1);
    checkVal("ra_addr", 64'(memAddr), 64'h80);
    repeat (5) tick();
    checkRx("ra_first",  0, 32'h80, 32'h180);
    checkRx("ra_second", 1, 32'h81, 32'h181);

    // Address wrap at 2^32.
    doReset();
    repeat (3) tick();
    redirectAddr = 32'hFFFF_FFFF;
    redirect     = 1'b1;
    tick();
    redirect = 1'b0;
    rxQ.delete();
    repeat (6) tick();
    checkRx("wr_top",  0, 32'hFFFF_FFFF, 32'h0000_00FF);
    checkRx("wr_zero", 1, 32'h0000_0000, 32'h0000_0100);

    // Asynchronous reset mid-request.
    memLat     = 3;
    instrReady = 1'b0;
    doReset();
    repeat (4) tick();
    checkVal("ar_preVal",  64'(instrValid), 64'd1);
    checkVal("ar_preReq",  64'(memReq),     64'd1);
    checkVal("ar_preAddr", 64'(memAddr),    64'd1);
    rst = 1'b1;
    #1;
    checkVal("ar_req",  64'(memReq),     64'd0);
    checkVal("ar_val",  64'(instrValid), 64'd0);
    checkVal("ar_addr", 64'(memAddr),    64'd0);
    checkVal("ar_data", 64'(instrData),  64'd0);
    tick();
    rst = 1'b0;
    tick();
    checkVal("ar_postReq",  64'(memReq),  64'd1);
    checkVal("ar_postAddr", 64'(memAddr), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
